// File: rtl/cpu_bus_seq_pkg.sv
// Shared types and constants for the 65c816 multi-byte bus access sequencer.
package cpu_bus_seq_pkg;

  // Bus direction values driven on which_rdwr.
  localparam logic WH_RDWR_READ  = 1'b0;
  localparam logic WH_RDWR_WRITE = 1'b1;

  typedef enum logic [1:0] {
    WRAP_LINEAR = 2'd0,
    WRAP_BANK   = 2'd1,
    WRAP_PAGE   = 2'd2
  } cpu_wrap_t;

  localparam int SEQ_STATE_MSB = 1;

  typedef enum logic [SEQ_STATE_MSB:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_ACCESS = 2'd1,
    SEQ_DONE   = 2'd2
  } seq_state_t;

  // Zero-length commands still move one byte; oversize ones saturate.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_bytes);
    if (len == 0) return 1;
    if (len > max_bytes) return max_bytes;
    return len;
  endfunction

endpackage

// File: rtl/cpu_bus_seq_if.sv
// Command and memory-bus bundle between the CPU control FSM, the sequencer
// and external memory.
interface cpu_bus_seq_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int MAX_BYTES  = 3,
  parameter int LEN_WIDTH  = 2
);
  logic                     enable;
  logic                     start;
  logic                     op_write;
  logic [LEN_WIDTH-1:0]     op_len;
  logic [ADDR_WIDTH-1:0]    op_addr;
  logic [1:0]               op_wrap;
  logic [8*MAX_BYTES-1:0]   op_wdata;
  logic                     busy;
  logic                     done;
  logic [8*MAX_BYTES-1:0]   rdata;
  logic                     req_rdwr;
  logic                     which_rdwr;
  logic [ADDR_WIDTH-1:0]    addr;
  logic [7:0]               data_out;
  logic [7:0]               data_in;
  logic                     mem_ready;

  modport master (
    output enable, start, op_write, op_len, op_addr, op_wrap, op_wdata,
    output data_in, mem_ready,
    input  busy, done, rdata, req_rdwr, which_rdwr, addr, data_out
  );

  modport slave (
    input  enable, start, op_write, op_len, op_addr, op_wrap, op_wdata,
    input  data_in, mem_ready,
    output busy, done, rdata, req_rdwr, which_rdwr, addr, data_out
  );
endinterface

// File: rtl/cpu_addr_incr.sv
// Wrap-aware address adder: base + offset with the carry confined to the
// page (low 8 bits) or bank (low 16 bits) when requested.
module cpu_addr_incr
  import cpu_bus_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = 24,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic [ADDR_WIDTH-1:0]   base,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [1:0]              wrap,
  output logic [ADDR_WIDTH-1:0]   address
);
  logic [ADDR_WIDTH-1:0] sum;
  logic [ADDR_WIDTH-1:0] mask;

  // Bits outside the mask come from base untouched, so carries cannot escape.
  always_comb begin
    sum  = base + ADDR_WIDTH'(offset);
    mask = '1;
    if (wrap == WRAP_PAGE) begin
      mask = ADDR_WIDTH'(16'h00FF);
    end else if (wrap == WRAP_BANK) begin
      mask = ADDR_WIDTH'(16'hFFFF);
    end
    address = (base & ~mask) | (sum & mask);
  end
endmodule

// File: rtl/cpu_bus_seq.sv
// Multi-byte memory access sequencer: one command becomes a little-endian run
// of single-byte bus cycles with wait states and 65c816 page/bank wrap.
module cpu_bus_seq
  import cpu_bus_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int MAX_BYTES  = 3,
  parameter int LEN_WIDTH  = 2
) (
  input logic          clk,
  input logic          rst,
  cpu_bus_seq_if.slave bus
);
  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int DW    = 8 * MAX_BYTES;

  seq_state_t            state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [IDX_W-1:0]      last_reg, last_next;
  logic                  write_reg, write_next;
  logic [1:0]            wrap_reg, wrap_next;
  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [DW-1:0]         wdata_reg, wdata_next;
  logic [DW-1:0]         rdata_reg, rdata_next;
  logic                  req_reg, req_next;
  logic                  which_reg, which_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [7:0]            dout_reg, dout_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;

  logic [IDX_W-1:0]      idx_inc;
  logic [IDX_W-1:0]      last_cmd;
  logic [ADDR_WIDTH-1:0] step_addr;
  logic                  last_byte;
  logic [7:0]            wbyte [MAX_BYTES];

  assign idx_inc   = idx_reg + 1'b1;
  assign last_byte = (idx_reg == last_reg);
  assign last_cmd  = IDX_W'(clamp_len(32'(bus.op_len), MAX_BYTES) - 1);

  for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_wlane
    assign wbyte[gi] = wdata_reg[8*gi +: 8];
  end

  // Address of the byte that follows the current one.
  cpu_addr_incr #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OFFSET_WIDTH (IDX_W)
  ) u_addr_incr (
    .base    (base_reg),
    .offset  (idx_inc),
    .wrap    (wrap_reg),
    .address (step_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SEQ_IDLE;
    end else if (bus.enable) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEQ_IDLE:   if (bus.start) state_next = SEQ_ACCESS;
      SEQ_ACCESS: if (bus.mem_ready && last_byte) state_next = SEQ_DONE;
      SEQ_DONE:   state_next = SEQ_IDLE;
      default:    state_next = SEQ_IDLE;
    endcase
  end

  // Computes the next value of every registered output so the bus pins never
  // see a combinational path from any input.
  always_comb begin
    idx_next   = idx_reg;
    last_next  = last_reg;
    write_next = write_reg;
    wrap_next  = wrap_reg;
    base_next  = base_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    req_next   = req_reg;
    which_next = which_reg;
    addr_next  = addr_reg;
    dout_next  = dout_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    case (state_reg)
      SEQ_IDLE: begin
        if (bus.start) begin
          write_next = bus.op_write;
          wrap_next  = bus.op_wrap;
          base_next  = bus.op_addr;
          wdata_next = bus.op_wdata;
          last_next  = last_cmd;
          idx_next   = '0;
          if (!bus.op_write) rdata_next = '0;
          req_next   = 1'b1;
          which_next = bus.op_write ? WH_RDWR_WRITE : WH_RDWR_READ;
          addr_next  = bus.op_addr;
          dout_next  = bus.op_write ? bus.op_wdata[7:0] : 8'h00;
          busy_next  = 1'b1;
        end
      end
      SEQ_ACCESS: begin
        if (bus.mem_ready) begin
          if (!write_reg) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
              if (idx_reg == IDX_W'(k)) rdata_next[8*k +: 8] = bus.data_in;
            end
          end
          if (last_byte) begin
            req_next  = 1'b0;
            done_next = 1'b1;
          end else begin
            idx_next  = idx_inc;
            addr_next = step_addr;
            dout_next = write_reg ? wbyte[idx_inc] : 8'h00;
          end
        end
      end
      SEQ_DONE: begin
        done_next = 1'b0;
        busy_next = 1'b0;
      end
      default: begin
        req_next  = 1'b0;
        done_next = 1'b0;
        busy_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg   <= '0;
      last_reg  <= '0;
      write_reg <= 1'b0;
      wrap_reg  <= WRAP_LINEAR;
      base_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      req_reg   <= 1'b0;
      which_reg <= WH_RDWR_READ;
      addr_reg  <= '0;
      dout_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (bus.enable) begin
      idx_reg   <= idx_next;
      last_reg  <= last_next;
      write_reg <= write_next;
      wrap_reg  <= wrap_next;
      base_reg  <= base_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      req_reg   <= req_next;
      which_reg <= which_next;
      addr_reg  <= addr_next;
      dout_reg  <= dout_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.req_rdwr   = req_reg;
  assign bus.which_rdwr = which_reg;
  assign bus.addr       = addr_reg;
  assign bus.data_out   = dout_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.rdata      = rdata_reg;
endmodule

// File: tb/tb_cpu_bus_seq.sv
// Scoreboard bench for cpu_bus_seq: 24-bit and 16-bit address builds.
module tb_cpu_bus_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct { logic [23:0] addr; logic which; logic [7:0] dout; } bus_exp_t;
  typedef struct { logic [23:0] rdata; int cyc; } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  bus_exp_t  bus16_q[$];
  done_exp_t done16_q[$];

  cpu_bus_seq_if #(.ADDR_WIDTH(24), .MAX_BYTES(3), .LEN_WIDTH(2)) bus ();
  cpu_bus_seq_if #(.ADDR_WIDTH(16), .MAX_BYTES(3), .LEN_WIDTH(2)) bus16 ();

  cpu_bus_seq #(.ADDR_WIDTH(24), .MAX_BYTES(3), .LEN_WIDTH(2)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );
  cpu_bus_seq #(.ADDR_WIDTH(16), .MAX_BYTES(3), .LEN_WIDTH(2)) dut16 (
    .clk (clk), .rst (rst), .bus (bus16.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_model(input logic [23:0] a);
    case (a)
      24'h012344: return 8'h11;
      24'h012345: return 8'h22;
      24'h012346: return 8'h33;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  assign bus.data_in   = mem_model(bus.addr);
  assign bus16.data_in = mem_model({8'h00, bus16.addr});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 24-bit build: every requesting cycle must match the head
  // of the expected queue; the head is retired when the cycle completes.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_rdwr) begin
        if (bus_q.size() == 0) begin
          check("unexpected_bus_cycle", 32'(bus.addr), 32'h0);
        end else begin
          check("bus_addr", 32'(bus.addr), 32'(bus_q[0].addr));
          check("which_rdwr", 32'(bus.which_rdwr), 32'(bus_q[0].which));
          check("data_out", 32'(bus.data_out), 32'(bus_q[0].dout));
          if (bus.enable && bus.mem_ready) void'(bus_q.pop_front());
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'h0);
        end else begin
          done_exp_t e;
          e = done_q.pop_front();
          $display("[TB] 24b done rdata=0x%06h cycle=%0d", bus.rdata, cyc);
          check("rdata", 32'(bus.rdata), 32'(e.rdata));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("busy_in_done", 32'(bus.busy), 32'h1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus16.req_rdwr && bus16.mem_ready && bus16.enable) begin
        if (bus16_q.size() == 0) begin
          check("unexpected_bus16_cycle", 32'(bus16.addr), 32'h0);
        end else begin
          bus_exp_t b;
          b = bus16_q.pop_front();
          check("bus16_addr", 32'(bus16.addr), 32'(b.addr));
        end
      end
      if (bus16.done) begin
        if (done16_q.size() == 0) begin
          check("unexpected_done16", 32'(bus16.done), 32'h0);
        end else begin
          done_exp_t e;
          e = done16_q.pop_front();
          $display("[TB] 16b done rdata=0x%06h cycle=%0d", bus16.rdata, cyc);
          check("rdata16", 32'(bus16.rdata), 32'(e.rdata));
          check("done16_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic exp_bus(input logic [23:0] a, input logic w, input logic [7:0] d);
    bus_q.push_back('{addr: a, which: w, dout: d});
  endtask

  task automatic issue(input logic wr, input logic [1:0] len, input logic [23:0] a,
                       input logic [1:0] wrap, input logic [23:0] wd,
                       input logic [23:0] exp_rdata, input int nbytes, input int extra);
    done_q.push_back('{rdata: exp_rdata, cyc: cyc + 1 + nbytes + extra});
    bus.op_write = wr;
    bus.op_len   = len;
    bus.op_addr  = a;
    bus.op_wrap  = wrap;
    bus.op_wdata = wd;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit use16);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (use16 ? bus16.done : bus.done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'h1);
    if (!seen) begin
      bus_q.delete(); done_q.delete(); bus16_q.delete(); done16_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdwr"}, 32'(bus.req_rdwr), 32'h0);
    check({tag, "_which_rdwr"}, 32'(bus.which_rdwr), 32'h0);
    check({tag, "_addr"}, 32'(bus.addr), 32'h0);
    check({tag, "_data_out"}, 32'(bus.data_out), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    check({tag, "_rdata"}, 32'(bus.rdata), 32'h0);
  endtask

  initial begin
    bus.enable = 1'b1; bus.start = 1'b0; bus.op_write = 1'b0; bus.op_len = 2'd0;
    bus.op_addr = '0; bus.op_wrap = 2'd0; bus.op_wdata = '0; bus.mem_ready = 1'b1;
    bus16.enable = 1'b1; bus16.start = 1'b0; bus16.op_write = 1'b0; bus16.op_len = 2'd0;
    bus16.op_addr = '0; bus16.op_wrap = 2'd0; bus16.op_wdata = '0; bus16.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 3-byte linear read
    exp_bus(24'h012344, 1'b0, 8'h00);
    exp_bus(24'h012345, 1'b0, 8'h00);
    exp_bus(24'h012346, 1'b0, 8'h00);
    issue(1'b0, 2'd3, 24'h012344, 2'd0, 24'h0, 24'h332211, 3, 0);
    check("busy_after_accept", 32'(bus.busy), 32'h1);
    wait_done("t1", 20, 1'b0);

    // 2-byte page-wrap write; rdata keeps the last read result
    exp_bus(24'h0000FF, 1'b1, 8'hEF);
    exp_bus(24'h000000, 1'b1, 8'hBE);
    issue(1'b1, 2'd2, 24'h0000FF, 2'd2, 24'h00BEEF, 24'h332211, 2, 0);
    wait_done("t2", 20, 1'b0);

    // Bank wrap versus linear carry into the bank byte
    exp_bus(24'h7EFFFF, 1'b0, 8'h00);
    exp_bus(24'h7E0000, 1'b0, 8'h00);
    issue(1'b0, 2'd2, 24'h7EFFFF, 2'd1, 24'h0, 24'h005AA5, 2, 0);
    wait_done("t3_bank", 20, 1'b0);
    exp_bus(24'h7EFFFF, 1'b0, 8'h00);
    exp_bus(24'h7F0000, 1'b0, 8'h00);
    issue(1'b0, 2'd2, 24'h7EFFFF, 2'd0, 24'h0, 24'h005AA5, 2, 0);
    wait_done("t3_linear", 20, 1'b0);

    // Wait states with start pulses that must be ignored
    exp_bus(24'h000010, 1'b0, 8'h00);
    bus.mem_ready = 1'b0;
    issue(1'b0, 2'd1, 24'h000010, 2'd0, 24'h0, 24'h00004A, 1, 3);
    bus.start = 1'b1; bus.op_write = 1'b1; bus.op_addr = 24'h000999; bus.op_len = 2'd3;
    @(posedge clk); #1;
    check("t4_busy_wait", 32'(bus.busy), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("t4", 20, 1'b0);

    // Reset aborts a 3-byte write after two bytes
    exp_bus(24'h000200, 1'b1, 8'h44);
    exp_bus(24'h000201, 1'b1, 8'h55);
    bus.op_len = 2'd3;
    bus.start = 1'b1; bus.op_write = 1'b1; bus.op_addr = 24'h000200;
    bus.op_wrap = 2'd0; bus.op_wdata = 24'h665544;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("t5");
    repeat (4) @(posedge clk);
    #1;
    check("t5_bus_q_empty", 32'(bus_q.size()), 32'h0);

    // Clock enable low for two cycles during ACCESS
    exp_bus(24'h000030, 1'b0, 8'h00);
    exp_bus(24'h000031, 1'b0, 8'h00);
    issue(1'b0, 2'd2, 24'h000030, 2'd0, 24'h0, 24'h006B6A, 2, 2);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    check("t6_frozen_addr", 32'(bus.addr), 32'h30);
    check("t6_frozen_req", 32'(bus.req_rdwr), 32'h1);
    @(posedge clk); #1;
    check("t6_frozen_addr2", 32'(bus.addr), 32'h30);
    bus.enable = 1'b1;
    wait_done("t6_enable", 20, 1'b0);

    // op_len of 0 moves exactly one byte
    exp_bus(24'h000040, 1'b0, 8'h00);
    issue(1'b0, 2'd0, 24'h000040, 2'd0, 24'h0, 24'h00001A, 1, 0);
    wait_done("t6_len0", 20, 1'b0);

    // 16-bit build: linear read across 0xFFFF wraps to 0x0000
    bus16_q.push_back('{addr: 24'h00FFFF, which: 1'b0, dout: 8'h00});
    bus16_q.push_back('{addr: 24'h000000, which: 1'b0, dout: 8'h00});
    bus16_q.push_back('{addr: 24'h000001, which: 1'b0, dout: 8'h00});
    done16_q.push_back('{rdata: 24'h5B5AA5, cyc: cyc + 1 + 3});
    bus16.op_write = 1'b0; bus16.op_len = 2'd3; bus16.op_addr = 16'hFFFF;
    bus16.op_wrap = 2'd0; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    wait_done("t6_addr16", 20, 1'b1);

    check("end_bus_q", 32'(bus_q.size()), 32'h0);
    check("end_done_q", 32'(done_q.size()), 32'h0);
    check("end_bus16_q", 32'(bus16_q.size()), 32'h0);
    check("end_done16_q", 32'(done16_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
